// File: rtl/dynamic_obst_ctl.sv
// dynamic_obst_ctl: horizontal motion controller for one obstacle column.
//
// The obstacle steps sideways by STEP pixels once every FRAME_DIV frames.
// A frame is marked by a rising edge of vblank_in. Because updates follow
// that edge, x_pos only changes during blanking.
//
// Build option:
//   DYN_OBST_BOUNCE_EN  When defined, the obstacle bounces between X_MIN and X_MAX.
//                       When undefined, it moves right only and wraps to X_MIN.
//
// Ports:
//   pclk        pixel clock; all state changes on its rising edge
//   rst         asynchronous active-high reset
//   vblank_in   vertical blanking from the timing chain
//   start       one-cycle pulse: begin or resume motion
//   stop        one-cycle pulse: freeze motion at the current position
//   restart     one-cycle pulse: return to X_MIN and go idle
//   x_pos       obstacle left edge
//   y_pos       obstacle top edge (constant Y_START)
//   moving      high while in RUN
//   frame_tick  one-cycle pulse per detected vblank rising edge
module dynamic_obst_ctl #(
  parameter int unsigned X_MIN     = 0,
  parameter int unsigned X_MAX     = 974,
  parameter int unsigned Y_START   = 100,
  parameter int unsigned STEP      = 4,
  parameter int unsigned FRAME_DIV = 1
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        vblank_in,
  input  logic        start,
  input  logic        stop,
  input  logic        restart,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        moving,
  output logic        frame_tick
);

  localparam logic [12:0] XMin13  = 13'(X_MIN);
  localparam logic [12:0] XMax13  = 13'(X_MAX);
  localparam logic [12:0] Step13  = 13'(STEP);
  localparam logic [7:0]  LastCnt = 8'(FRAME_DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e      state_q, state_d;
  logic        vblank_q;
  logic        tick_q;
  logic [7:0]  cnt_q, cnt_d;
  logic [11:0] x_q, x_d;
  logic [12:0] x_ext, x_sum;
  logic        run_tick;
  logic        update;

  // A coinciding stop or restart suppresses this frame's progress entirely.
  assign run_tick = (state_q == StRun) & tick_q & ~stop & ~restart;
  assign update   = run_tick & (cnt_q == LastCnt);
  assign x_ext    = {1'b0, x_q};
  assign x_sum    = x_ext + Step13;

  // Edge detector for vblank_in.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      vblank_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      vblank_q <= vblank_in;
      tick_q   <= vblank_in & ~vblank_q;
    end
  end

  // State register.
  always_ff @(posedge pclk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic. Priority is restart, then stop, then start.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle:  if (start && !stop) state_d = StRun;
        StRun:   if (stop)           state_d = StPause;
        StPause: if (start && !stop) state_d = StRun;
        default:                     state_d = StIdle;
      endcase
    end
  end

  // Frame divider.
  always_comb begin
    cnt_d = cnt_q;
    if (restart)       cnt_d = 8'd0;
    else if (run_tick) cnt_d = (cnt_q == LastCnt) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
      x_q   <= 12'(X_MIN);
    end else begin
      cnt_q <= cnt_d;
      x_q   <= x_d;
    end
  end

`ifdef DYN_OBST_BOUNCE_EN
  // Direction: 0 = right, 1 = left.
  logic dir_q, dir_d;

  always_comb begin
    x_d   = x_q;
    dir_d = dir_q;
    if (restart) begin
      x_d   = 12'(X_MIN);
      dir_d = 1'b0;
    end else if (update) begin
      if (!dir_q) begin
        if (x_sum >= XMax13) begin
          x_d   = 12'(X_MAX);
          dir_d = 1'b1;
        end else begin
          x_d = x_sum[11:0];
        end
      end else begin
        if (x_ext <= XMin13 + Step13) begin
          x_d   = 12'(X_MIN);
          dir_d = 1'b0;
        end else begin
          // Safe: the branch above guarantees x_q > STEP.
          x_d = x_q - 12'(STEP);
        end
      end
    end
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  always_comb begin
    x_d = x_q;
    if (restart) begin
      x_d = 12'(X_MIN);
    end else if (update) begin
      if (x_sum > XMax13) x_d = 12'(X_MIN);
      else                x_d = x_sum[11:0];
    end
  end

  // XMin13 only matters for the bouncing build.
  logic unused_xmin;
  assign unused_xmin = ^XMin13;
`endif

  // Outputs.
  always_comb begin
    x_pos      = x_q;
    y_pos      = 12'(Y_START);
    moving     = (state_q == StRun);
    frame_tick = tick_q;
  end

endmodule

// File: tb/tb_dynamic_obst_ctl.sv
module tb_dynamic_obst_ctl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        vblank_in = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        restart = 1'b0;
  logic [11:0] x_pos, y_pos, x2, y2;
  logic        moving, frame_tick, mv2, tk2;

  int checks = 0;
  int failures = 0;

  always #5 pclk = ~pclk;

  dynamic_obst_ctl dut (
    .pclk(pclk), .rst(rst), .vblank_in(vblank_in), .start(start), .stop(stop),
    .restart(restart), .x_pos(x_pos), .y_pos(y_pos), .moving(moving),
    .frame_tick(frame_tick)
  );

  dynamic_obst_ctl #(.FRAME_DIV(3)) dut3 (
    .pclk(pclk), .rst(rst), .vblank_in(vblank_in), .start(start), .stop(stop),
    .restart(restart), .x_pos(x2), .y_pos(y2), .moving(mv2), .frame_tick(tk2)
  );

  typedef struct {
    logic        st, sp, rs, vb;
    logic [11:0] x;
    logic        mv, tk;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(logic st, logic sp, logic rs, logic vb, logic [11:0] x,
                              logic mv, logic tk);
    vec_t v;
    v.st = st; v.sp = sp; v.rs = rs; v.vb = vb; v.x = x; v.mv = mv; v.tk = tk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the active edge, then sample 1 ns after it.
  task automatic cyc(input logic st, input logic sp, input logic rs, input logic vb);
    @(negedge pclk);
    start = st; stop = sp; restart = rs; vblank_in = vb;
    @(posedge pclk);
    #1;
  endtask

  task automatic frame();
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
  endtask

  logic [11:0] exp_wrap1, exp_wrap2;
  logic [11:0] exp_div3[6];
  logic        reached;

  initial begin
    //                 st sp rs vb  x      mv tk
    vecs[0]  = mk(1, 0, 0, 0, 12'd0,  1, 0);
    vecs[1]  = mk(0, 0, 0, 1, 12'd0,  1, 1);
    vecs[2]  = mk(0, 0, 0, 1, 12'd4,  1, 0);
    vecs[3]  = mk(0, 0, 0, 0, 12'd4,  1, 0);
    vecs[4]  = mk(0, 0, 0, 1, 12'd4,  1, 1);
    vecs[5]  = mk(0, 0, 0, 0, 12'd8,  1, 0);
    vecs[6]  = mk(0, 0, 0, 1, 12'd8,  1, 1);
    vecs[7]  = mk(0, 0, 0, 1, 12'd12, 1, 0);
    vecs[8]  = mk(1, 1, 0, 0, 12'd12, 0, 0);  // stop beats start
    vecs[9]  = mk(0, 0, 0, 1, 12'd12, 0, 1);
    vecs[10] = mk(0, 0, 0, 0, 12'd12, 0, 0);
    vecs[11] = mk(0, 0, 0, 1, 12'd12, 0, 1);
    vecs[12] = mk(0, 0, 0, 0, 12'd12, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 12'd12, 1, 0);
    vecs[14] = mk(0, 0, 0, 1, 12'd12, 1, 1);
    vecs[15] = mk(0, 0, 0, 0, 12'd16, 1, 0);
    vecs[16] = mk(0, 0, 0, 1, 12'd16, 1, 1);
    vecs[17] = mk(0, 1, 0, 0, 12'd16, 0, 0);  // stop on qualifying tick
    vecs[18] = mk(1, 0, 0, 0, 12'd16, 1, 0);
    vecs[19] = mk(0, 0, 0, 1, 12'd16, 1, 1);
    vecs[20] = mk(0, 0, 1, 0, 12'd0,  0, 0);  // restart on qualifying tick
    vecs[21] = mk(0, 0, 0, 1, 12'd0,  0, 1);
    vecs[22] = mk(0, 0, 0, 0, 12'd0,  0, 0);

    exp_div3[0] = 12'd0; exp_div3[1] = 12'd0; exp_div3[2] = 12'd4;
    exp_div3[3] = 12'd4; exp_div3[4] = 12'd4; exp_div3[5] = 12'd8;
`ifdef DYN_OBST_BOUNCE_EN
    exp_wrap1 = 12'd974; exp_wrap2 = 12'd970;
`else
    exp_wrap1 = 12'd0;   exp_wrap2 = 12'd4;
`endif

    // Reset state
    repeat (3) @(posedge pclk);
    #1;
    chk("reset_outputs", {20'd0, x_pos, 1'b0, moving, frame_tick}, 32'd0);
    chk("reset_y", {20'd0, y_pos}, 32'd100);
    @(negedge pclk);
    rst = 1'b0;
    @(posedge pclk);
    #1;

    for (int i = 0; i < 23; i++) begin
      cyc(vecs[i].st, vecs[i].sp, vecs[i].rs, vecs[i].vb);
      chk($sformatf("vec%0d", i), {6'd0, x_pos, moving, frame_tick, y_pos},
          {6'd0, vecs[i].x, vecs[i].mv, vecs[i].tk, 12'd100});
    end

    // Asynchronous reset mid-RUN, between edges
    cyc(1, 0, 0, 0);
    frame();
    frame();
    chk("pre_rst_x", {20'd0, x_pos}, 32'd8);
    @(posedge pclk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst", {19'd0, x_pos, moving, frame_tick}, 32'd0);
    @(negedge pclk);
    rst = 1'b0;
    frame();
    chk("post_rst_idle", {19'd0, x_pos, moving, frame_tick}, 32'd0);

    // FRAME_DIV=3: updates only after frames 3 and 6
    cyc(1, 0, 0, 0);
    for (int f = 0; f < 6; f++) begin
      frame();
      chk($sformatf("div3_frame%0d", f + 1), {19'd0, x2, mv2, tk2},
          {19'd0, exp_div3[f], 1'b1, 1'b0});
    end
    chk("div3_y", {20'd0, y2}, 32'd100);
    chk("div1_after6", {20'd0, x_pos}, 32'd24);

    // Pause holds across 5 frames, start resumes from the held value
    cyc(0, 1, 0, 0);
    for (int f = 0; f < 5; f++) begin
      frame();
      chk($sformatf("pause_frame%0d", f + 1), {19'd0, x_pos, moving, 1'b0},
          {19'd0, 12'd24, 1'b0, 1'b0});
    end
    cyc(1, 0, 0, 0);
    frame();
    chk("resume", {19'd0, x_pos, moving, 1'b0}, {19'd0, 12'd28, 1'b1, 1'b0});

    // Right bound: walk to 972, then wrap or bounce
    cyc(0, 0, 1, 0);
    chk("restart_x", {20'd0, x_pos}, 32'd0);
    cyc(1, 0, 0, 0);
    reached = 1'b0;
    for (int f = 0; f < 300 && !reached; f++) begin
      frame();
      if (x_pos == 12'd972) reached = 1'b1;
    end
    chk("reach_972", {31'd0, reached}, 32'd1);
    frame();
    chk("bound_update1", {20'd0, x_pos}, {20'd0, exp_wrap1});
    frame();
    chk("bound_update2", {20'd0, x_pos}, {20'd0, exp_wrap2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dynamic_obst_ctl.md
DYNAMIC_OBST_CTL -- requirements
Module: dynamic_obst_ctl

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high.
REQ-002 Parameter X_MIN, default 0, SHALL set the leftmost legal obstacle x_pos.
REQ-003 Parameter X_MAX, default 974, SHALL set the rightmost legal obstacle x_pos (1024 - obstacle width 50).
REQ-004 Parameter Y_START, default 100, SHALL set the constant y_pos of the obstacle column.
REQ-005 Parameter STEP, default 4, SHALL set the pixels moved per update (1..63).
REQ-006 Parameter FRAME_DIV, default 1, SHALL set the frames per update (1..255).
REQ-007 pclk  in  1  pixel clock; all state changes on its rising edge.
REQ-008 rst  in  1  asynchronous active-high reset.
REQ-009 vblank_in  in  1  vertical blanking from the timing chain; a frame boundary is its rising edge.
REQ-010 start  in  1  one-cycle pulse: begin or resume motion.
REQ-011 stop  in  1  one-cycle pulse: freeze motion at the current position.
REQ-012 restart  in  1  one-cycle pulse: return to the initial position and idle.
REQ-013 x_pos  out  12  obstacle left edge, driven to the obstacle drawer.
REQ-014 y_pos  out  12  obstacle top edge; SHALL equal Y_START at all times.
REQ-015 moving  out  1  high while in RUN.
REQ-016 frame_tick  out  1  one-cycle pulse on each detected vblank rising edge.

Function
REQ-017 The FSM SHALL have states IDLE, RUN and PAUSE.
REQ-018 IDLE->RUN on start; RUN->PAUSE on stop; PAUSE->RUN on start; any state->IDLE on restart.
REQ-019 Priority SHALL be restart > stop > start when pulses coincide.
REQ-020 restart SHALL load x_pos=X_MIN, direction=right, and frame counter=0.
REQ-021 vblank_in SHALL be registered once; frame_tick=vblank_in & ~vblank_d, registered, so it is high the cycle after vblank_in first samples high.
REQ-022 The frame counter (8 bit) SHALL increment on frame_tick only in RUN, and it SHALL hold in IDLE and PAUSE.
REQ-023 An update SHALL occur on the frame_tick where counter==FRAME_DIV-1, and the counter then SHALL clear to 0.
REQ-024 x_pos SHALL change on the clock edge following the qualifying frame_tick, exactly once per update, and never during active video.
REQ-025 Moving right: if x_pos+STEP >= X_MAX then x_pos=X_MAX and direction flips left; else x_pos+=STEP.
REQ-026 Moving left: if x_pos <= X_MIN+STEP then x_pos=X_MIN and direction flips right; else x_pos-=STEP.
REQ-027 Arithmetic SHALL be 13-bit unsigned so that x_pos+STEP does not overflow, and x_pos SHALL never leave [X_MIN, X_MAX].
REQ-028 A restart coinciding with an update SHALL win: x_pos=X_MIN.
REQ-029 A stop coinciding with a qualifying frame_tick SHALL suppress that update.

Reset
REQ-030 On rst: state=IDLE, x_pos=X_MIN, y_pos=Y_START, direction=right, counter=0, vblank_d=0, moving=0, frame_tick=0.
REQ-031 Reset SHALL take effect immediately, including mid-frame and mid-RUN; release SHALL need no vblank edge to settle.

Configuration
REQ-032 With macro DYN_OBST_BOUNCE_EN defined, motion SHALL reverse at the bounds per REQ-025/026.
REQ-033 Without DYN_OBST_BOUNCE_EN, motion SHALL be rightward only: if x_pos+STEP > X_MAX then x_pos=X_MIN, else x_pos+=STEP; the direction register SHALL be absent.

Verification
REQ-034 Reset, start, 3 vblank rising edges (STEP=4, FRAME_DIV=1) -> x_pos 0->4->8->12, each change one cycle after frame_tick.
REQ-035 FRAME_DIV=3, RUN, 6 frames -> x_pos changes only after frames 3 and 6 (0->4->8).
REQ-036 With BOUNCE_EN, x_pos=972, moving right, update -> x_pos=974, direction left; next update -> 970.
REQ-037 Without BOUNCE_EN, x_pos=972, update -> x_pos=0.
REQ-038 stop and start in the same cycle while in RUN -> PAUSE, and x_pos holds over 5 frames; start -> resumes from the held value.
REQ-039 Assert rst mid-RUN between pclk edges -> outputs reach reset values before the next pclk edge; restart coinciding with an update -> x_pos=0, state IDLE.
